// File: rtl/mempool_dma_burst_splitter_pkg.sv
// Shared types and constants for the MemPool DMA burst splitter.
package mempool_dma_burst_splitter_pkg;

    localparam int unsigned NumBackends = 4;
    localparam int unsigned ChunkBytes  = 256;
    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned OutstWidth  = 8;
    localparam int unsigned IdWidth     = 4;

    localparam int unsigned ChunkOffW = $clog2(ChunkBytes);
    localparam int unsigned BeIdxW    = (NumBackends > 1) ? $clog2(NumBackends) : 1;

    typedef logic [AddrWidth-1:0] addr_t;

    // iDMA 1D burst request
    typedef struct packed {
        logic [IdWidth-1:0] id;
        addr_t              src;
        addr_t              dst;
        addr_t              num_bytes;
        logic [3:0]         cache_src;
        logic [3:0]         cache_dst;
        logic [1:0]         burst_src;
        logic [1:0]         burst_dst;
        logic               decouple_rw;
        logic               deburst;
        logic               serialize;
    } burst_req_t;

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        WAIT
    } state_e;

    // Number of set bits in a per-backend completion vector.
    function automatic logic [OutstWidth-1:0] popcount(input logic [NumBackends-1:0] v);
        logic [OutstWidth-1:0] n;
        n = '0;
        for (int i = 0; i < NumBackends; i++) begin
            n = n + OutstWidth'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mempool_dma_chunk_calc.sv
// Size and owning backend of the next chunk: the chunk runs from the current
// destination up to the next granule boundary, or to the end of the request.
module mempool_dma_chunk_calc
    import mempool_dma_burst_splitter_pkg::*;
(
    input  logic [ChunkOffW+BeIdxW-1:0] dst_low_i,
    input  logic [AddrWidth-1:0]        rem_i,
    output logic [AddrWidth-1:0]        chunk_o,
    output logic [BeIdxW-1:0]           tgt_o
);

    logic [AddrWidth-1:0] room;

    assign room    = AddrWidth'(ChunkBytes) - AddrWidth'(dst_low_i[ChunkOffW-1:0]);
    assign chunk_o = (rem_i < room) ? rem_i : room;
    assign tgt_o   = (NumBackends > 1) ? dst_low_i[ChunkOffW +: BeIdxW] : '0;

endmodule

// File: rtl/mempool_dma_burst_splitter.sv
// Splits one DMA burst into granule-aligned chunks, steers each chunk to the
// backend owning its destination, and reports completion of the whole burst.
module mempool_dma_burst_splitter
    import mempool_dma_burst_splitter_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  burst_req_t                        burst_req_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output burst_req_t [NumBackends-1:0]      burst_req_o,
    output logic [NumBackends-1:0]            valid_o,
    input  logic [NumBackends-1:0]            ready_i,
    input  logic [NumBackends-1:0]            trans_complete_i,
    output logic                              trans_complete_o,
    output logic                              idle_o
);

    state_e                state_q;
    burst_req_t            req_q;
    addr_t                 src_q, dst_q, rem_q;
    logic [OutstWidth-1:0] outst_q, outst_d;
    logic                  tc_q;

    addr_t                 chunk;
    logic [BeIdxW-1:0]     tgt;
    logic                  accept, issue_valid, issue;
    logic [OutstWidth:0]   outst_inc, outst_dec;

    mempool_dma_chunk_calc u_calc (
        .dst_low_i (dst_q[ChunkOffW+BeIdxW-1:0]),
        .rem_i     (rem_q),
        .chunk_o   (chunk),
        .tgt_o     (tgt)
    );

    // Reset overrides every handshake-facing output in the cycle it is asserted.
    assign ready_o          = !rst_i && (state_q == IDLE);
    assign accept           = valid_i && ready_o;
    assign issue_valid      = !rst_i && (state_q == SPLIT) && (outst_q != '1);
    assign issue            = issue_valid && ready_i[tgt];
    assign idle_o           = rst_i || ((state_q == IDLE) && (outst_q == '0));
    assign trans_complete_o = tc_q && !rst_i;

    // Steer the current chunk to its owning backend; all other lanes stay zero.
    always_comb begin
        // NOTE: default every output first so no path through the block infers a latch.
        valid_o     = '0;
        burst_req_o = '0;
        if (issue_valid) begin
            valid_o[tgt]               = 1'b1;
            burst_req_o[tgt]           = req_q;
            burst_req_o[tgt].src       = src_q;
            burst_req_o[tgt].dst       = dst_q;
            burst_req_o[tgt].num_bytes = chunk;
        end
    end

    // Outstanding chunks: add this cycle's issue, remove all completions, floor at zero.
    always_comb begin
        outst_inc = {1'b0, outst_q} + (OutstWidth + 1)'(issue);
        outst_dec = {1'b0, popcount(trans_complete_i)};
        outst_d   = (outst_dec > outst_inc) ? '0 : OutstWidth'(outst_inc - outst_dec);
    end

    // Request FSM: latch a burst, walk it chunk by chunk, then wait for completions.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            outst_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            tc_q    <= 1'b0;
            outst_q <= outst_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (burst_req_i.num_bytes == '0) begin
                            tc_q <= 1'b1;
                        end else begin
                            req_q   <= burst_req_i;
                            src_q   <= burst_req_i.src;
                            dst_q   <= burst_req_i.dst;
                            rem_q   <= burst_req_i.num_bytes;
                            state_q <= SPLIT;
                        end
                    end
                end
                SPLIT: begin
                    if (issue) begin
                        src_q <= src_q + chunk;
                        dst_q <= dst_q + chunk;
                        rem_q <= rem_q - chunk;
                        if (rem_q == chunk) begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (outst_d == '0) begin
                        state_q <= IDLE;
                        tc_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Recover the active lane's payload from the outputs and recompute its chunk independently.
    logic [ChunkOffW+BeIdxW-1:0] chk_dst_low;
    addr_t                       chk_num, chk_chunk;
    logic [BeIdxW-1:0]           chk_tgt;

    always_comb begin
        chk_dst_low = '0;
        chk_num     = '0;
        for (int i = 0; i < NumBackends; i++) begin
            chk_dst_low = chk_dst_low | burst_req_o[i].dst[ChunkOffW+BeIdxW-1:0];
            chk_num     = chk_num | burst_req_o[i].num_bytes;
        end
    end

    mempool_dma_chunk_calc u_chk (
        .dst_low_i (chk_dst_low),
        .rem_i     (rem_q),
        .chunk_o   (chk_chunk),
        .tgt_o     (chk_tgt)
    );

    // Invariants: one valid lane, payload consistent with its lane, no counter underflow.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            a_onehot:    assert ($onehot0(valid_o));
            if (|valid_o) begin
                a_steer: assert (valid_o[chk_tgt] && (chk_num == chk_chunk));
            end
            a_underflow: assert (outst_dec <= outst_inc);
        end
    end

endmodule
